// File: rtl/cache_assoc_fill_pkg.sv
// Shared types and sizing helpers for the fully-associative fill cache.
package cache_assoc_fill_pkg;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;

    function automatic int offset_width(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int vidx_width(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/cache_assoc_fill_way.sv
// One cache line: valid bit, tag, byte storage and the tag comparator.
module cache_way
    import cache_assoc_fill_pkg::*;
#(
    parameter int TAG_WIDTH  = 12,
    parameter int BLOCK_SIZE = 8,
    localparam int OFF_W     = offset_width(BLOCK_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    input  logic [OFF_W-1:0]     lookup_off,
    input  logic                 wr_en,
    input  logic [OFF_W-1:0]     wr_off,
    input  logic [7:0]           wr_data,
    input  logic                 tag_load,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 set_valid,
    input  logic                 clr_valid,
    output logic                 hit,
    output logic [7:0]           rdata
);

    logic                 valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [7:0]           data_q [BLOCK_SIZE];

    // A completing fill must survive a same-cycle flush, so set wins over clear.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (clr_valid) valid_d = 1'b0;
        if (set_valid) valid_d = 1'b1;
        if (tag_load)  tag_d   = tag_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // NOTE: tag and byte storage carry no reset; valid_q gates every use of them.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (wr_en) data_q[wr_off] <= wr_data;
    end

    assign hit   = valid_q && (tag_q == lookup_tag);
    assign rdata = hit ? data_q[lookup_off] : 8'h00;

endmodule

// File: rtl/cache_assoc_fill.sv
// Fully-associative read-allocate byte cache with round-robin victims and a
// critical-byte-first line-fill engine on a byte-wide memory port.
module cache_assoc_fill
    import cache_assoc_fill_pkg::*;
#(
    parameter int NUM_WAYS    = 2,
    parameter int TAG_WIDTH   = 12,
    parameter int BLOCK_SIZE  = 8,
    localparam int OFF_W      = offset_width(BLOCK_SIZE),
    localparam int VIDX       = vidx_width(NUM_WAYS),
    localparam int ADDR_WIDTH = TAG_WIDTH + OFF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  flush,
    output logic                  cpu_hit,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    fill_state_t          state_q, state_d;
    logic [TAG_WIDTH-1:0] fill_tag_q, fill_tag_d;
    logic [VIDX-1:0]      fill_way_q, fill_way_d;
    logic [OFF_W-1:0]     fill_off_q, fill_off_d;
    logic [OFF_W-1:0]     start_off_q, start_off_d;
    logic [VIDX-1:0]      victim_q, victim_d;
    logic                 mem_req_q, mem_req_d;
    logic                 cpu_stall_q, cpu_stall_d;

    logic [TAG_WIDTH-1:0] cpu_tag;
    logic [OFF_W-1:0]     cpu_off;
    logic [NUM_WAYS-1:0]  way_hit;
    logic [7:0]           way_rdata [NUM_WAYS];
    logic [VIDX-1:0]      hit_idx;
    logic                 start_fill, fill_done, last_byte;

    logic [NUM_WAYS-1:0]  way_wr_en, way_tag_load, way_set_valid, way_clr_valid;
    logic [OFF_W-1:0]     wr_off;
    logic [7:0]           wr_data;

    assign cpu_tag = cpu_addr[ADDR_WIDTH-1:OFF_W];
    assign cpu_off = cpu_addr[OFF_W-1:0];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        cache_way #(.TAG_WIDTH(TAG_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_way (
            .clk       (clk),
            .rst       (rst),
            .lookup_tag(cpu_tag),
            .lookup_off(cpu_off),
            .wr_en     (way_wr_en[w]),
            .wr_off    (wr_off),
            .wr_data   (wr_data),
            .tag_load  (way_tag_load[w]),
            .tag_in    (fill_tag_q),
            .set_valid (way_set_valid[w]),
            .clr_valid (way_clr_valid[w]),
            .hit       (way_hit[w]),
            .rdata     (way_rdata[w])
        );
    end

    // Descending scan leaves the lowest matching index in hit_idx.
    always_comb begin
        hit_idx = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_idx = VIDX'(w);
        end
    end

    assign cpu_hit   = |way_hit;
    assign cpu_rdata = cpu_hit ? way_rdata[hit_idx] : 8'h00;

    assign start_fill = (state_q == IDLE) && cpu_en && !cpu_wr && !cpu_hit;
    assign last_byte  = (fill_off_q + OFF_W'(1)) == start_off_q;
    assign fill_done  = (state_q == FILL) && mem_ack && last_byte;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_fill) state_d = FILL;
            FILL:    if (fill_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-way write, tag and valid controls.
    always_comb begin
        way_wr_en     = '0;
        way_tag_load  = '0;
        way_set_valid = '0;
        way_clr_valid = {NUM_WAYS{flush}};
        wr_off        = (state_q == FILL) ? fill_off_q : cpu_off;
        wr_data       = (state_q == FILL) ? mem_rdata : cpu_wdata;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (state_q == IDLE && cpu_en && cpu_wr && cpu_hit && hit_idx == VIDX'(w))
                way_wr_en[w] = 1'b1;
            if (state_q == FILL && mem_ack && fill_way_q == VIDX'(w))
                way_wr_en[w] = 1'b1;
            if (fill_done && fill_way_q == VIDX'(w)) begin
                way_tag_load[w]  = 1'b1;
                way_set_valid[w] = 1'b1;
            end
            if (start_fill && victim_q == VIDX'(w))
                way_clr_valid[w] = 1'b1;
        end
    end

    // Fill engine and victim pointer.
    always_comb begin
        fill_tag_d  = fill_tag_q;
        fill_way_d  = fill_way_q;
        fill_off_d  = fill_off_q;
        start_off_d = start_off_q;
        victim_d    = victim_q;
        mem_req_d   = mem_req_q;
        cpu_stall_d = cpu_stall_q;
        if (start_fill) begin
            fill_tag_d  = cpu_tag;
            fill_way_d  = victim_q;
            fill_off_d  = cpu_off;
            start_off_d = cpu_off;
            mem_req_d   = 1'b1;
            cpu_stall_d = 1'b1;
        end else if (state_q == FILL && mem_ack) begin
            fill_off_d = fill_off_q + OFF_W'(1);
            if (last_byte) begin
                victim_d    = (victim_q == VIDX'(NUM_WAYS - 1)) ? '0 : victim_q + VIDX'(1);
                mem_req_d   = 1'b0;
                cpu_stall_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_tag_q  <= '0;
            fill_way_q  <= '0;
            fill_off_q  <= '0;
            start_off_q <= '0;
            victim_q    <= '0;
            mem_req_q   <= 1'b0;
            cpu_stall_q <= 1'b0;
        end else begin
            fill_tag_q  <= fill_tag_d;
            fill_way_q  <= fill_way_d;
            fill_off_q  <= fill_off_d;
            start_off_q <= start_off_d;
            victim_q    <= victim_d;
            mem_req_q   <= mem_req_d;
            cpu_stall_q <= cpu_stall_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign cpu_stall = cpu_stall_q;
    assign mem_addr  = {fill_tag_q, fill_off_q};

endmodule

// File: tb/tb_cache_assoc_fill.sv
// Randomised self-checking bench for cache_assoc_fill against a line-level cache model.
module tb_cache_assoc_fill;

    localparam int NW = 2;
    localparam int BS = 8;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_en = 1'b0, cpu_wr = 1'b0, flush = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic          cpu_hit, cpu_stall, mem_req;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    cache_assoc_fill #(.NUM_WAYS(NW), .TAG_WIDTH(12), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .flush(flush), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // External memory and its responder: acks after resp_wait idle cycles per byte.
    logic [7:0]    ext_mem [1 << AW];
    logic [AW-1:0] acked_addrs [$];
    int            resp_wait = 0;
    int            wait_cnt = 0;
    logic          hold_valid = 1'b0;
    logic [AW-1:0] hold_addr = '0;

    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (hold_valid) check("mem_addr_hold", 32'(mem_addr), 32'(hold_addr));
            if (wait_cnt < resp_wait) begin
                mem_ack    = 1'b0;
                wait_cnt++;
                hold_valid = 1'b1;
                hold_addr  = mem_addr;
            end else begin
                mem_ack    = 1'b1;
                mem_rdata  = ext_mem[mem_addr];
                acked_addrs.push_back(mem_addr);
                wait_cnt   = 0;
                hold_valid = 1'b0;
            end
        end else begin
            mem_ack    = 1'b0;
            wait_cnt   = 0;
            hold_valid = 1'b0;
        end
    end

    // Reference model: whole lines, round-robin victim.
    logic        m_valid  [NW];
    logic [11:0] m_tag    [NW];
    logic [7:0]  m_data   [NW][BS];
    int          m_victim = 0;

    function automatic int model_lookup(input logic [AW-1:0] a);
        for (int w = 0; w < NW; w++)
            if (m_valid[w] && m_tag[w] == a[AW-1:3]) return w;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < NW; w++) m_valid[w] = 1'b0;
    endfunction

    function automatic void model_fill(input logic [AW-1:0] a);
        m_valid[m_victim] = 1'b1;
        m_tag[m_victim]   = a[AW-1:3];
        for (int i = 0; i < BS; i++) m_data[m_victim][i] = ext_mem[{a[AW-1:3], 3'(i)}];
        m_victim = (m_victim + 1) % NW;
    endfunction

    task automatic probe(input logic [AW-1:0] a, input string tag);
        int w;
        @(negedge clk);
        cpu_en = 1'b0; cpu_addr = a;
        #1;
        w = model_lookup(a);
        check({tag, "_hit"}, 32'(cpu_hit), 32'(w >= 0));
        check({tag, "_rdata"}, 32'(cpu_rdata), (w >= 0) ? 32'(m_data[w][a[2:0]]) : 32'h0);
    endtask

    task automatic check_fill_addrs(input logic [AW-1:0] a);
        check("fill_count", 32'(acked_addrs.size()), 32'(BS));
        for (int i = 0; i < BS && i < acked_addrs.size(); i++)
            check("fill_addr", 32'(acked_addrs[i]), 32'({a[AW-1:3], 3'(int'(a[2:0]) + i)}));
    endtask

    task automatic wait_stall_low(output int n);
        n = 1;
        while (cpu_stall && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (cpu_stall) check("stall_timeout", 32'(cpu_stall), 32'h0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int waits);
        int w, n;
        resp_wait = waits;
        acked_addrs.delete();
        @(negedge clk);
        cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        #1;
        w = model_lookup(a);
        check("rd_hit", 32'(cpu_hit), 32'(w >= 0));
        if (w >= 0) check("rd_rdata", 32'(cpu_rdata), 32'(m_data[w][a[2:0]]));
        @(negedge clk);
        cpu_en = 1'b0;
        if (w >= 0) begin
            check("rd_hit_nostall", 32'(cpu_stall), 32'h0);
        end else begin
            check("miss_stall", 32'(cpu_stall), 32'h1);
            check("miss_req", 32'(mem_req), 32'h1);
            check("miss_addr", 32'(mem_addr), 32'(a));
            m_valid[m_victim] = 1'b0;
            wait_stall_low(n);
            check("miss_latency", 32'(n), 32'(1 + BS * (1 + waits)));
            check("req_dropped", 32'(mem_req), 32'h0);
            check_fill_addrs(a);
            model_fill(a);
            probe(a, "refetch");
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
        int w;
        @(negedge clk);
        cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        #1;
        w = model_lookup(a);
        check("wr_hit", 32'(cpu_hit), 32'(w >= 0));
        @(negedge clk);
        cpu_en = 1'b0; cpu_wr = 1'b0;
        check("wr_nostall", 32'(cpu_stall), 32'h0);
        check("wr_noreq", 32'(mem_req), 32'h0);
        if (w >= 0) m_data[w][a[2:0]] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_stall", 32'(cpu_stall), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_hit", 32'(cpu_hit), 32'h0);
        check("rst_rdata", 32'(cpu_rdata), 32'h0);
        model_clear();
        m_victim = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts a miss on a, returns once acks bytes have been written into the line.
    task automatic start_partial(input logic [AW-1:0] a, input int acks);
        int seen = 0, guard = 0;
        resp_wait = 0;
        acked_addrs.delete();
        @(negedge clk);
        cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        @(negedge clk);
        cpu_en = 1'b0;
        m_valid[m_victim] = 1'b0;
        while (seen < acks && guard < 100) begin
            @(posedge clk);
            if (mem_ack) seen++;
            guard++;
        end
        check("partial_acks", 32'(seen), 32'(acks));
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) ext_mem[i] = 8'($urandom);
        model_clear();

        // 1: reset state, then the critical-byte-first fill of 0x1235
        do_reset();
        do_read(15'h1235, 0);

        // 2: round-robin eviction across three fills
        do_reset();
        do_read(15'h1000, 0);
        do_read(15'h2000, 0);
        do_read(15'h3000, 0);
        probe(15'h1000, "evicted");
        probe(15'h2000, "kept");

        // 3: write hit updates the byte, write miss allocates nothing
        do_write(15'h2003, 8'hA5);
        do_read(15'h2003, 0);
        check("wr_byte", 32'(cpu_rdata), 32'hA5);
        do_write(15'h4000, 8'h5A);
        probe(15'h4000, "wr_miss");

        // 4: slow memory, three wait cycles per byte
        do_read(15'h5005, 3);

        // 5: flush in the middle of a fill
        do_read(15'h0a12, 0);
        start_partial(15'h0b1c, 4);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_stall_low(n);
        check_fill_addrs(15'h0b1c);
        model_clear();
        model_fill(15'h0b1c);
        probe(15'h0b1c, "flush_fill");
        probe(15'h0a12, "flush_other");

        // 6: reset while a fill is running
        start_partial(15'h0c27, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(mem_req), 32'h0);
        check("midrst_stall", 32'(cpu_stall), 32'h0);
        model_clear();
        m_victim = 0;
        @(negedge clk);
        rst = 1'b0;
        probe(15'h0c27, "midrst_tag");
        probe(15'h0b1c, "midrst_old");

        // Random mix over a few tags so hits, misses and evictions all recur
        for (int k = 0; k < 60; k++) begin
            a = {12'h100 + 12'($urandom_range(0, 2)), 3'($urandom)};
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_read(a, $urandom_range(0, 1));
                4, 5, 6:    do_write(a, 8'($urandom));
                7, 8:       probe(a, "rnd_probe");
                default: begin
                    @(negedge clk);
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                    model_clear();
                    probe(a, "rnd_flush");
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
